// File: rtl/skid_buffer.sv
// ---------------------------------------------------------------------------
// skid_buffer
//
// Single-entry skid buffer between a valid/busy producer and a downstream
// consumer. The upstream busy flag comes straight from a flop, so the
// consumer's stall never reaches the producer combinationally. When the
// consumer is not stalling, a beat passes through with zero latency.
// A beat that is accepted while the consumer stalls is captured in the skid
// register and presented from the next cycle until it is consumed.
//
// Handshake:
//   A beat moves upstream -> buffer when (valid_i & ~busy_o) at a rising
//   edge. A beat moves buffer -> consumer when (valid_o & ~stall_i) at a
//   rising edge. While busy_o = 1 the producer holds data_i stable, and
//   valid_i/data_i are ignored.
//
// Ports (positional order):
//   clock_i  in   1      clock, rising edge
//   reset_i  in   1      synchronous, active-high reset
//   stall_i  in   1      consumer does not take the current output beat
//   data_o   out  WIDTH  payload to consumer
//   valid_o  out  1      data_o holds a valid beat
//   busy_o   out  1      upstream not-ready (registered)
//   data_i   in   WIDTH  payload from producer
//   valid_i  in   1      producer beat valid
//
// Parameters:
//   WIDTH    payload width in bits (>= 1), default 32
//
// Build option:
//   SKID_BUFFER_CLEAR_DATA_EN  when defined, the skid register is also
//                              cleared to zero by reset; otherwise only the
//                              full flag is reset.
// ---------------------------------------------------------------------------
module skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             stall_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i
);

    logic             r_full;
    logic [WIDTH-1:0] r_skid;

    // Beat accepted from upstream but not consumed this cycle: it must be
    // captured. Only possible while empty, since busy_o = full.
    logic w_capture;
    // Held beat leaves this cycle.
    logic w_release;

    assign w_capture = ~r_full & valid_i & stall_i;
    assign w_release = r_full & ~stall_i;

    assign valid_o = r_full | valid_i;
    assign data_o  = r_full ? r_skid : data_i;
    assign busy_o  = r_full;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_full <= 1'b0;
        end else if (w_capture) begin
            r_full <= 1'b1;
        end else if (w_release) begin
            r_full <= 1'b0;
        end
    end

`ifdef SKID_BUFFER_CLEAR_DATA_EN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_skid <= '0;
        end else if (w_capture) begin
            r_skid <= data_i;
        end
    end
`else
    // Plain enable flop: contents are only observed while r_full = 1, and
    // r_full is always set in the same cycle the register is loaded.
    always_ff @(posedge clock_i) begin
        if (w_capture) begin
            r_skid <= data_i;
        end
    end
`endif

endmodule

// File: tb/tb_skid_buffer.sv
module tb_skid_buffer;

    localparam int W = 32;
    localparam int N_BEATS = 1000;

    logic         clock_i;
    logic         reset_i;
    logic         stall_i;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         busy_o;
    logic [W-1:0] data_i;
    logic         valid_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    skid_buffer #(.WIDTH(W)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .stall_i (stall_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .data_i  (data_i),
        .valid_i (valid_i)
    );

    // ---------------- clock ----------------
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic valid, input logic [W-1:0] data);
        reset_i = rst;
        stall_i = stall;
        valid_i = valid;
        data_i  = data;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic         stall;
        logic         valid;
        logic [W-1:0] data;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stall, input logic valid, input logic [W-1:0] data,
                       input logic ev, input logic [W-1:0] ed, input logic eb);
        vec_t v;
        v.rst = rst; v.stall = stall; v.valid = valid; v.data = data;
        v.exp_valid = ev; v.exp_data = ed; v.exp_busy = eb;
        vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] next_beat;
        logic         pend;
        logic         b0;
        logic         acc;
        logic         con;
        logic [W-1:0] con_data;
        logic [W-1:0] exp_v;
        int           received;
        int           cycles;
        int           burst_cons;

        // Each row: inputs held for one cycle, outputs checked just before
        // the rising edge that ends the cycle.
        //   rst stall valid data           exp_valid exp_data        exp_busy
        add(0, 0, 1, 32'hA5A5_0001,         1, 32'hA5A5_0001, 0); // pass-through
        add(0, 0, 0, 32'h0000_0000,         0, 32'h0000_0000, 0); // busy stays 0
        add(0, 1, 1, 32'h0000_0011,         1, 32'h0000_0011, 0); // capture 0x11
        add(0, 1, 1, 32'h0000_0022,         1, 32'h0000_0011, 1); // held
        add(0, 1, 1, 32'h0000_0099,         1, 32'h0000_0011, 1); // hold, input ignored
        add(0, 1, 1, 32'hDEAD_BEEF,         1, 32'h0000_0011, 1);
        add(0, 1, 0, 32'h0000_0077,         1, 32'h0000_0011, 1);
        add(0, 1, 1, 32'h0000_0022,         1, 32'h0000_0011, 1);
        add(0, 0, 1, 32'h0000_0022,         1, 32'h0000_0011, 1); // 0x11 consumed
        add(0, 0, 1, 32'h0000_0022,         1, 32'h0000_0022, 0); // bubble gone, 0x22 passes
        add(0, 0, 0, 32'h0000_0000,         0, 32'h0000_0000, 0);
        add(0, 1, 1, 32'h0000_0033,         1, 32'h0000_0033, 0); // capture 0x33
        add(1, 1, 0, 32'h0000_0000,         1, 32'h0000_0033, 1); // reset while full
        add(0, 0, 0, 32'h0000_0044,         0, 32'h0000_0044, 0); // 0x33 discarded
        add(0, 1, 0, 32'h0000_0055,         0, 32'h0000_0055, 0); // stall with nothing valid
        add(0, 1, 1, 32'h0000_0066,         1, 32'h0000_0066, 0); // stall toggling: capture
        add(0, 0, 1, 32'h0000_0077,         1, 32'h0000_0066, 1); // consume 0x66, 0x77 refused
        add(0, 1, 1, 32'h0000_0077,         1, 32'h0000_0077, 0); // capture 0x77
        add(0, 0, 1, 32'h0000_0088,         1, 32'h0000_0077, 1); // consume 0x77
        add(0, 0, 0, 32'h0000_0000,         0, 32'h0000_0000, 0);

        // ---------------- reset ----------------
        drive(1, 0, 0, '0);
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        drive(0, 0, 1, 32'h1234_5678);
        #1;
        check("reset_busy",  {31'd0, busy_o},  32'd0);
        check("reset_valid", {31'd0, valid_o}, 32'd1);
        check("reset_data",  data_o,           32'h1234_5678);
        @(negedge clock_i);
        drive(0, 0, 0, '0);

        // ---------------- directed table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock_i);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].valid, vecs[i].data);
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_data", i),  data_o,           vecs[i].exp_data);
            check($sformatf("vec%0d_busy", i),  {31'd0, busy_o},  {31'd0, vecs[i].exp_busy});
        end

        // ---------------- reset-while-full sequence ----------------
        @(negedge clock_i);
        drive(0, 1, 1, 32'h0000_00AB);          // capture 0xAB
        @(negedge clock_i);
        drive(1, 1, 0, 32'h0000_0000);          // reset with 0xAB held
        #1;
        check("rst_seq_busy_before", {31'd0, busy_o}, 32'd1);
        @(negedge clock_i);
        drive(0, 1, 0, 32'h0000_0001);
        #1;
        check("rst_seq_busy_after",  {31'd0, busy_o},  32'd0);
        check("rst_seq_valid_after", {31'd0, valid_o}, 32'd0);
        check("rst_seq_data_after",  data_o,           32'h0000_0001);
`ifdef SKID_BUFFER_CLEAR_DATA_EN
        check("rst_seq_skid_cleared", dut.r_skid, 32'h0000_0000);
`endif

        // ---------------- random stress with scoreboard ----------------
        @(negedge clock_i);
        drive(0, 0, 0, '0);
        next_beat = '0;
        pend      = 1'b0;
        received  = 0;
        cycles    = 0;
        while ((next_beat < N_BEATS || exp_q.size() != 0) && cycles < 20000) begin
            @(negedge clock_i);
            cycles++;
            if (!pend) begin
                valid_i = (next_beat < N_BEATS) && ($urandom_range(0, 3) != 0);
                data_i  = next_beat;
            end
            stall_i = (next_beat < N_BEATS) ? ($urandom_range(0, 2) == 0) : 1'b0;
            #1;
            // busy_o must not move when only stall_i changes
            b0 = busy_o;
            stall_i = ~stall_i;
            #1;
            if (busy_o !== b0) check("busy_vs_stall", {31'd0, busy_o}, {31'd0, b0});
            stall_i = ~stall_i;
            #1;
            acc      = valid_i & ~busy_o;
            con      = valid_o & ~stall_i;
            con_data = data_o;
            if (acc) begin
                exp_q.push_back(data_i);
                next_beat = next_beat + 1;
                pend = 1'b0;
            end else begin
                pend = valid_i;
            end
            if (con) begin
                if (exp_q.size() == 0) begin
                    check("stress_unexpected_beat", con_data, 32'hFFFF_FFFF);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("stress_order", con_data, exp_v);
                    received++;
                end
            end
        end
        check("stress_timeout",   {31'd0, (cycles >= 20000)}, 32'd0);
        check("stress_received",  received,                   N_BEATS);
        check("stress_queue_empty", exp_q.size(),             32'd0);

        // ---------------- full-throughput burst ----------------
        @(negedge clock_i);
        drive(0, 0, 0, '0);                     // let any held beat drain
        @(negedge clock_i);
        drive(0, 0, 0, '0);
        burst_cons = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_i);
            drive(0, 0, 1, 32'h0000_5000 + i);
            #1;
            if (valid_o && !busy_o && data_o == (32'h0000_5000 + i)) burst_cons++;
        end
        check("burst_throughput", burst_cons, 32'd20);

        @(negedge clock_i);
        drive(0, 0, 0, '0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
